dmem_cache: RTL and testbench

- Blocking, direct-mapped, write-through, no-write-allocate data cache used by the memory stage.
- Receives the EX/MEM-latched control, address and store data, and returns load data.
- Raises BUSY to stall the pipeline through pipeline control while a miss or store is being serviced.
- Talks to backing memory over a single req/ack port.

---
 rtl/dmem_cache.sv | 198 +++++++++++++++++++
 tb/tb_dmem_cache.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache.sv
`default_nettype none
// ============================================================================
// dmem_cache : blocking, direct-mapped, write-through, no-write-allocate
//              data cache for the memory stage.
// Revision   : 1.0 - initial release
// ============================================================================
module dmem_cache #(
  parameter int LINES       = 16,
  parameter int IDX_W       = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  input  logic        flush,
  output logic [31:0] Rdata,
  output logic        BUSY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int TAG_W = 32 - 2 - IDX_W;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;
  localparam logic [1:0] ST_WR_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b01;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_word_addr;
  logic             w_hit;
  logic             w_load;
  logic             w_store;
  logic             w_none;
  logic             w_mem_busy;
  logic             w_timeout;
  logic             w_flush_now;
  logic             w_fill;
  logic             w_wr_upd;

  assign w_idx       = Addr[IDX_W+1:2];
  assign w_tag       = Addr[31:IDX_W+2];
  assign w_word_addr = {Addr[31:2], Addr[1:0] & 2'b00};
  assign w_hit       = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_load      = (MEM == OP_LOAD);
  assign w_store     = (MEM == OP_STORE);
  assign w_none      = !w_load && !w_store;
  assign w_mem_busy  = (state_q == ST_RD_MISS) || (state_q == ST_WR_THRU);
  // Timeout fires as the counter would reach MEM_TIMEOUT, so mem_req is high
  // for exactly MEM_TIMEOUT cycles before the err cycle.
  assign w_timeout   = w_mem_busy && !mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign w_flush_now = (state_q == ST_IDLE) && w_none && (flush || flush_pend_q);
  assign w_fill      = (state_q == ST_RD_MISS) && mem_ack;
  assign w_wr_upd    = (state_q == ST_WR_THRU) && mem_ack && w_hit;

  assign BUSY      = w_mem_busy ||
                     ((state_q == ST_IDLE) && ((w_load && !w_hit) || w_store));
  assign Rdata     = ((state_q == ST_IDLE) && w_load && w_hit) ? data_q[w_idx] : rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = 1'b0;
    valid_d      = valid_q;

    if (flush && !w_flush_now) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_load) begin
          if (w_hit) begin
            rdata_d = data_q[w_idx];
          end else begin
            state_d    = ST_RD_MISS;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = w_word_addr;
          end
        end else if (w_store) begin
          state_d     = ST_WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = w_word_addr;
          mem_wdata_d = Wdata;
        end else if (w_flush_now) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
      end

      ST_RD_MISS, ST_WR_THRU: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == ST_RD_MISS) begin
            valid_d[w_idx] = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_WR_DONE;
          end
        end else if (w_timeout) begin
          // Abandon the access without touching the arrays; IDLE re-evaluates the op.
          mem_req_d = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WR_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data storage carries no reset; valid_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tag_q[w_idx]  <= w_tag;
      data_q[w_idx] <= mem_rdata;
    end else if (w_wr_upd) begin
      data_q[w_idx] <= Wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_cache.sv
`default_nettype none
// ============================================================================
// tb_dmem_cache : directed self-checking bench for dmem_cache.
// Revision      : 1.0 - initial release
// ============================================================================
module tb_dmem_cache;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b01;

  logic        clk;
  logic        rst;
  logic [1:0]  MEM;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic        flush;
  logic [31:0] Rdata;
  logic        BUSY;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_cache #(
    .LINES       (16),
    .IDX_W       (4),
    .MEM_TIMEOUT (255)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .MEM       (MEM),
    .Addr      (Addr),
    .Wdata     (Wdata),
    .flush     (flush),
    .Rdata     (Rdata),
    .BUSY      (BUSY),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    MEM   = op;
    Addr  = a;
    Wdata = wd;
  endtask

  // Plays backing memory for the op already presented: acks on the lat-th
  // cycle of mem_req, counts BUSY cycles, and stops on the retire cycle.
  task automatic serve(input int lat, input logic [31:0] rd,
                       output int busy_n, output int req_n,
                       output logic we, output logic [31:0] addr,
                       output logic [31:0] wd, output logic [31:0] rdat);
    int   req_cyc;
    logic prev_req;
    logic done;
    busy_n   = 0;
    req_n    = 0;
    req_cyc  = 0;
    prev_req = 1'b0;
    done     = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wd       = '0;
    rdat     = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
      #1;
      if (mem_req && !prev_req) begin
        req_n++;
        we   = mem_we;
        addr = mem_addr;
        wd   = mem_wdata;
      end
      prev_req = mem_req;
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          req_cyc   = 0;
        end
      end
      if (!BUSY) begin
        done = 1'b1;
        rdat = Rdata;
      end else begin
        busy_n++;
      end
    end
    mem_ack = 1'b0;
    chk("op_retired", 32'(done), 32'd1);
  endtask

  int          busy_n;
  int          req_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rdat;
  logic        got_err;
  logic        req_at_err;
  logic        busy_at_err;

  initial begin
    rst       = 1'b0;
    MEM       = OP_NONE;
    Addr      = '0;
    Wdata     = '0;
    flush     = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_Rdata", Rdata, 32'h0);
    chk("rst_BUSY", 32'(BUSY), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Cold load miss, memory latency 3.
    set_op(OP_LOAD, 32'h0000_0010, 32'h0);
    serve(3, 32'hDEAD_BEEF, busy_n, req_n, we, addr, wd, rdat);
    chk("miss_busy_cycles", 32'(busy_n), 32'd4);
    chk("miss_req_count", 32'(req_n), 32'd1);
    chk("miss_we", 32'(we), 32'd0);
    chk("miss_addr", addr, 32'h0000_0010);
    chk("miss_rdata", rdat, 32'hDEAD_BEEF);

    set_op(OP_NONE, 32'h0000_0010, 32'h0);
    #1;
    chk("none_holds_rdata", Rdata, 32'hDEAD_BEEF);

    set_op(OP_LOAD, 32'h0000_0010, 32'h0);
    serve(3, 32'h0BAD_0BAD, busy_n, req_n, we, addr, wd, rdat);
    chk("hit_busy_cycles", 32'(busy_n), 32'd0);
    chk("hit_req_count", 32'(req_n), 32'd0);
    chk("hit_rdata", rdat, 32'hDEAD_BEEF);

    // Store hit, ack after 2 cycles of mem_req.
    set_op(OP_STORE, 32'h0000_0010, 32'h1234_5678);
    serve(2, 32'h0, busy_n, req_n, we, addr, wd, rdat);
    chk("st_busy_cycles", 32'(busy_n), 32'd3);
    chk("st_req_count", 32'(req_n), 32'd1);
    chk("st_we", 32'(we), 32'd1);
    chk("st_addr", addr, 32'h0000_0010);
    chk("st_wdata", wd, 32'h1234_5678);

    set_op(OP_LOAD, 32'h0000_0010, 32'h0);
    serve(1, 32'h0BAD_0BAD, busy_n, req_n, we, addr, wd, rdat);
    chk("st_hit_req_count", 32'(req_n), 32'd0);
    chk("st_hit_rdata", rdat, 32'h1234_5678);

    // Store miss: written through, not allocated.
    set_op(OP_STORE, 32'h0000_0080, 32'hAAAA_5555);
    serve(1, 32'h0, busy_n, req_n, we, addr, wd, rdat);
    chk("stmiss_busy_cycles", 32'(busy_n), 32'd2);
    chk("stmiss_addr", addr, 32'h0000_0080);
    chk("stmiss_wdata", wd, 32'hAAAA_5555);

    set_op(OP_LOAD, 32'h0000_0080, 32'h0);
    serve(1, 32'hCAFE_0080, busy_n, req_n, we, addr, wd, rdat);
    chk("noalloc_req_count", 32'(req_n), 32'd1);
    chk("noalloc_busy_cycles", 32'(busy_n), 32'd2);
    chk("noalloc_rdata", rdat, 32'hCAFE_0080);

    // Index aliasing: 0x00, 0x40 and 0x80 all map to line 0.
    set_op(OP_LOAD, 32'h0000_0000, 32'h0);
    serve(1, 32'h0000_0A00, busy_n, req_n, we, addr, wd, rdat);
    chk("alias0_req_count", 32'(req_n), 32'd1);
    chk("alias0_rdata", rdat, 32'h0000_0A00);

    set_op(OP_LOAD, 32'h0000_0040, 32'h0);
    serve(1, 32'h0000_0B40, busy_n, req_n, we, addr, wd, rdat);
    chk("alias40_req_count", 32'(req_n), 32'd1);
    chk("alias40_addr", addr, 32'h0000_0040);
    chk("alias40_rdata", rdat, 32'h0000_0B40);

    set_op(OP_LOAD, 32'h0000_0000, 32'h0);
    serve(1, 32'h0000_0A01, busy_n, req_n, we, addr, wd, rdat);
    chk("realias0_req_count", 32'(req_n), 32'd1);
    chk("realias0_rdata", rdat, 32'h0000_0A01);

    set_op(OP_LOAD, 32'h0000_0000, 32'h0);
    serve(1, 32'h0BAD_0BAD, busy_n, req_n, we, addr, wd, rdat);
    chk("realias0_hit_req", 32'(req_n), 32'd0);
    chk("realias0_hit_rdata", rdat, 32'h0000_0A01);

    // Unanswered load times out; flush raised while the miss is pending.
    set_op(OP_LOAD, 32'h0000_0020, 32'h0);
    req_n       = 0;
    got_err     = 1'b0;
    req_at_err  = 1'b1;
    busy_at_err = 1'b0;
    for (int c = 0; c < 400 && !got_err; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      flush = (c == 5);
      #1;
      if (err) begin
        got_err     = 1'b1;
        req_at_err  = mem_req;
        busy_at_err = BUSY;
      end else if (mem_req) begin
        req_n++;
      end
    end
    flush = 1'b0;
    chk("to_err_seen", 32'(got_err), 32'd1);
    chk("to_req_cycles", 32'(req_n), 32'd255);
    chk("to_req_dropped", 32'(req_at_err), 32'd0);
    chk("to_retry_busy", 32'(busy_at_err), 32'd1);

    serve(1, 32'h2020_2020, busy_n, req_n, we, addr, wd, rdat);
    chk("retry_req_count", 32'(req_n), 32'd1);
    chk("retry_busy_cycles", 32'(busy_n), 32'd2);
    chk("retry_rdata", rdat, 32'h2020_2020);

    // First IDLE-with-none cycle applies the latched flush.
    set_op(OP_NONE, 32'h0000_0020, 32'h0);
    set_op(OP_LOAD, 32'h0000_0020, 32'h0);
    serve(1, 32'h2020_2021, busy_n, req_n, we, addr, wd, rdat);
    chk("flush20_req_count", 32'(req_n), 32'd1);
    chk("flush20_rdata", rdat, 32'h2020_2021);

    set_op(OP_LOAD, 32'h0000_0010, 32'h0);
    serve(1, 32'h1234_5678, busy_n, req_n, we, addr, wd, rdat);
    chk("flush10_req_count", 32'(req_n), 32'd1);

    // Reset in the middle of a miss, then a stray ack.
    set_op(OP_LOAD, 32'h0000_0030, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_req_drop", 32'(mem_req), 32'd0);
    MEM = OP_NONE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("stray_ack_busy", 32'(BUSY), 32'd0);
    chk("stray_ack_err", 32'(err), 32'd0);

    set_op(OP_LOAD, 32'h0000_0010, 32'h0);
    serve(1, 32'h1111_0010, busy_n, req_n, we, addr, wd, rdat);
    chk("postrst_req_count", 32'(req_n), 32'd1);
    chk("postrst_rdata", rdat, 32'h1111_0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
